alu_issue_ctrl: RTL and testbench



---
 rtl/alu_issue_ctrl_pkg.sv | 77 +++++++
 rtl/alu_regfile.sv | 51 +++++
 rtl/alu_issue_ctrl.sv | 164 ++++++++++++++++
 tb/tb_alu_issue_ctrl.sv | 308 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_issue_ctrl_pkg.sv
// Shared definitions for the ALU issue controller: opcodes, instruction field
// positions, FSM states, response flag layout and the instruction decoder.
package alu_issue_ctrl_pkg;

    localparam int DATA_W   = 16;
    localparam int NREGS    = 8;
    localparam int REG_AW   = 3;
    localparam int IMM_W    = 6;
    localparam int FLAG_W   = 5;
    localparam int ALU_OP_W = 3;

    // Instruction field positions
    localparam int OP_MSB  = 15;
    localparam int OP_LSB  = 12;
    localparam int FA_MSB  = 11;
    localparam int FA_LSB  = 9;
    localparam int FB_MSB  = 8;
    localparam int FB_LSB  = 6;
    localparam int FC_MSB  = 5;
    localparam int FC_LSB  = 3;
    localparam int IMM_MSB = 5;

    localparam logic [3:0] OP_ADD  = 4'd0;
    localparam logic [3:0] OP_SUB  = 4'd1;
    localparam logic [3:0] OP_AND  = 4'd2;
    localparam logic [3:0] OP_OR   = 4'd3;
    localparam logic [3:0] OP_SLT  = 4'd4;
    localparam logic [3:0] OP_BNE  = 4'd5;
    localparam logic [3:0] OP_ADDI = 4'd6;

    // Bit positions inside rsp_flags = {cout, lt, eq, gt, ov}
    localparam int FLAG_COUT = 4;
    localparam int FLAG_LT   = 3;
    localparam int FLAG_EQ   = 2;
    localparam int FLAG_GT   = 1;
    localparam int FLAG_OV   = 0;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ISSUE   = 2'd1,
        ST_CAPTURE = 2'd2,
        ST_RESP    = 2'd3
    } state_t;

    typedef struct packed {
        logic [3:0]        op;
        logic [REG_AW-1:0] rd;
        logic [REG_AW-1:0] rs;
        logic [REG_AW-1:0] rt;
        logic [IMM_W-1:0]  imm;
        logic              legal;
        logic              is_bne;
        logic              use_imm;
        logic              writes_rd;
    } decode_t;

    function automatic logic [DATA_W-1:0] sext_imm(input logic [IMM_W-1:0] imm);
        return {{(DATA_W-IMM_W){imm[IMM_MSB]}}, imm};
    endfunction

    // BNE places its two sources where R-type puts rd/rs, so the read
    // addresses are steered here rather than in the datapath.
    function automatic decode_t decode(input logic [DATA_W-1:0] instr);
        decode_t d;
        d.op        = instr[OP_MSB:OP_LSB];
        d.legal     = (d.op <= OP_ADDI);
        d.is_bne    = (d.op == OP_BNE);
        d.use_imm   = (d.op == OP_ADDI);
        d.rd        = instr[FA_MSB:FA_LSB];
        d.rs        = d.is_bne ? instr[FA_MSB:FA_LSB] : instr[FB_MSB:FB_LSB];
        d.rt        = d.is_bne ? instr[FB_MSB:FB_LSB] : instr[FC_MSB:FC_LSB];
        d.imm       = instr[IMM_MSB:0];
        d.writes_rd = d.legal && !d.is_bne && (d.rd != '0);
        return d;
    endfunction

endpackage

// File: rtl/alu_regfile.sv
// 8x16 register file: one synchronous write port, three combinational reads.
// Entry 0 is never written, so it always reads as zero.
module alu_regfile
    import alu_issue_ctrl_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              we,
    input  logic [REG_AW-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [REG_AW-1:0] rs_addr,
    output logic [DATA_W-1:0] rs_data,
    input  logic [REG_AW-1:0] rt_addr,
    output logic [DATA_W-1:0] rt_data,
    input  logic [REG_AW-1:0] dbg_addr,
    output logic [DATA_W-1:0] dbg_data
);

    logic [DATA_W-1:0] regs_reg [NREGS];
    logic [NREGS-1:0]  wsel;

    genvar gi;
    generate
        for (gi = 0; gi < NREGS; gi++) begin : g_wsel
            if (gi == 0) begin : g_zero
                assign wsel[gi] = 1'b0;
            end else begin : g_rw
                assign wsel[gi] = we && (waddr == REG_AW'(gi));
            end
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREGS; i++) begin
                regs_reg[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NREGS; i++) begin
                if (wsel[i]) begin
                    regs_reg[i] <= wdata;
                end
            end
        end
    end

    assign rs_data  = regs_reg[rs_addr];
    assign rt_data  = regs_reg[rt_addr];
    assign dbg_data = regs_reg[dbg_addr];

endmodule

// File: rtl/alu_issue_ctrl.sv
// Issue controller in front of the combinational 16-bit ALU: accepts one
// instruction, issues registered operands, captures the result and responds.
module alu_issue_ctrl
    import alu_issue_ctrl_pkg::*;
(
    input  logic                clk,
    input  logic                rst_n,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [DATA_W-1:0]   in_instr,
    output logic [DATA_W-1:0]   alu_x,
    output logic [DATA_W-1:0]   alu_y,
    output logic [ALU_OP_W-1:0] alu_op,
    output logic                alu_cin,
    input  logic [DATA_W-1:0]   alu_out,
    input  logic                alu_cout,
    input  logic                alu_lt,
    input  logic                alu_eq,
    input  logic                alu_gt,
    input  logic                alu_ov,
    output logic                rsp_valid,
    input  logic                rsp_ready,
    output logic [DATA_W-1:0]   rsp_data,
    output logic [FLAG_W-1:0]   rsp_flags,
    output logic                rsp_branch,
    output logic [DATA_W-1:0]   rsp_offset,
    output logic                rsp_err,
    input  logic                ext_we,
    input  logic [REG_AW-1:0]   ext_waddr,
    input  logic [DATA_W-1:0]   ext_wdata,
    input  logic [REG_AW-1:0]   dbg_raddr,
    output logic [DATA_W-1:0]   dbg_rdata
);

    state_t                state_reg;
    logic [DATA_W-1:0]     instr_reg;
    decode_t               dec;

    logic [DATA_W-1:0]     alu_x_reg;
    logic [DATA_W-1:0]     alu_y_reg;
    logic [ALU_OP_W-1:0]   alu_op_reg;

    logic                  rsp_valid_reg;
    logic [DATA_W-1:0]     rsp_data_reg;
    logic [FLAG_W-1:0]     rsp_flags_reg;
    logic                  rsp_branch_reg;
    logic [DATA_W-1:0]     rsp_offset_reg;
    logic                  rsp_err_reg;

    logic                  rf_we;
    logic [REG_AW-1:0]     rf_waddr;
    logic [DATA_W-1:0]     rf_wdata;
    logic [DATA_W-1:0]     rs_data;
    logic [DATA_W-1:0]     rt_data;
    logic [FLAG_W-1:0]     flags_now;
    logic                  in_idle;
    logic                  in_capture;

    assign dec        = decode(instr_reg);
    assign in_idle    = (state_reg == ST_IDLE);
    assign in_capture = (state_reg == ST_CAPTURE);

    // Preload writes and writeback never overlap: one is IDLE-only, the
    // other CAPTURE-only, so a single write port suffices.
    assign rf_we    = (in_idle && ext_we) || (in_capture && dec.writes_rd);
    assign rf_waddr = in_capture ? dec.rd  : ext_waddr;
    assign rf_wdata = in_capture ? alu_out : ext_wdata;

    always_comb begin
        flags_now            = '0;
        flags_now[FLAG_COUT] = alu_cout;
        flags_now[FLAG_LT]   = alu_lt;
        flags_now[FLAG_EQ]   = alu_eq;
        flags_now[FLAG_GT]   = alu_gt;
        flags_now[FLAG_OV]   = alu_ov;
    end

    alu_regfile u_regfile (
        .clk      (clk),
        .rst_n    (rst_n),
        .we       (rf_we),
        .waddr    (rf_waddr),
        .wdata    (rf_wdata),
        .rs_addr  (dec.rs),
        .rs_data  (rs_data),
        .rt_addr  (dec.rt),
        .rt_data  (rt_data),
        .dbg_addr (dbg_raddr),
        .dbg_data (dbg_rdata)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg      <= ST_IDLE;
            instr_reg      <= '0;
            alu_x_reg      <= '0;
            alu_y_reg      <= '0;
            alu_op_reg     <= '0;
            rsp_valid_reg  <= 1'b0;
            rsp_data_reg   <= '0;
            rsp_flags_reg  <= '0;
            rsp_branch_reg <= 1'b0;
            rsp_offset_reg <= '0;
            rsp_err_reg    <= 1'b0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (in_valid) begin
                        instr_reg <= in_instr;
                        state_reg <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    if (!dec.legal) begin
                        // Illegal ops skip the ALU entirely; operands stay put.
                        rsp_valid_reg  <= 1'b1;
                        rsp_err_reg    <= 1'b1;
                        rsp_data_reg   <= '0;
                        rsp_flags_reg  <= '0;
                        rsp_branch_reg <= 1'b0;
                        rsp_offset_reg <= '0;
                        state_reg      <= ST_RESP;
                    end else begin
                        alu_x_reg  <= rs_data;
                        alu_y_reg  <= dec.use_imm ? sext_imm(dec.imm) : rt_data;
                        alu_op_reg <= dec.op[ALU_OP_W-1:0];
                        state_reg  <= ST_CAPTURE;
                    end
                end
                ST_CAPTURE: begin
                    rsp_valid_reg  <= 1'b1;
                    rsp_err_reg    <= 1'b0;
                    rsp_data_reg   <= alu_out;
                    rsp_flags_reg  <= flags_now;
                    rsp_branch_reg <= dec.is_bne && !alu_eq;
                    rsp_offset_reg <= dec.is_bne ? sext_imm(dec.imm) : '0;
                    state_reg      <= ST_RESP;
                end
                ST_RESP: begin
                    if (rsp_ready) begin
                        rsp_valid_reg <= 1'b0;
                        state_reg     <= ST_IDLE;
                    end
                end
                default: begin
                    state_reg <= ST_IDLE;
                end
            endcase
        end
    end

    assign in_ready   = in_idle;
    assign alu_x      = alu_x_reg;
    assign alu_y      = alu_y_reg;
    assign alu_op     = alu_op_reg;
    assign alu_cin    = 1'b0;
    assign rsp_valid  = rsp_valid_reg;
    assign rsp_data   = rsp_data_reg;
    assign rsp_flags  = rsp_flags_reg;
    assign rsp_branch = rsp_branch_reg;
    assign rsp_offset = rsp_offset_reg;
    assign rsp_err    = rsp_err_reg;

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Randomized self-checking bench for alu_issue_ctrl with a behavioural ALU
// and an array-based architectural model of the register file.
module tb_alu_issue_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_instr;
    logic [15:0] alu_x, alu_y;
    logic [2:0]  alu_op;
    logic        alu_cin;
    logic [15:0] alu_out;
    logic        alu_cout, alu_lt, alu_eq, alu_gt, alu_ov;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [15:0] rsp_data;
    logic [4:0]  rsp_flags;
    logic        rsp_branch;
    logic [15:0] rsp_offset;
    logic        rsp_err;
    logic        ext_we;
    logic [2:0]  ext_waddr;
    logic [15:0] ext_wdata;
    logic [2:0]  dbg_raddr;
    logic [15:0] dbg_rdata;

    int tests  = 0;
    int failed = 0;
    logic [15:0] model [8];

    always #20 clk = ~clk;

    alu_issue_ctrl dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr),
        .alu_x(alu_x), .alu_y(alu_y), .alu_op(alu_op), .alu_cin(alu_cin),
        .alu_out(alu_out), .alu_cout(alu_cout), .alu_lt(alu_lt), .alu_eq(alu_eq),
        .alu_gt(alu_gt), .alu_ov(alu_ov),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
        .rsp_flags(rsp_flags), .rsp_branch(rsp_branch), .rsp_offset(rsp_offset),
        .rsp_err(rsp_err),
        .ext_we(ext_we), .ext_waddr(ext_waddr), .ext_wdata(ext_wdata),
        .dbg_raddr(dbg_raddr), .dbg_rdata(dbg_rdata)
    );

    // Behavioural ALU: returns {out[15:0], cout, lt, eq, gt, ov}
    function automatic logic [20:0] alu_f(input logic [15:0] x, input logic [15:0] y,
                                          input logic [2:0] op);
        logic [16:0] w;
        logic [15:0] o;
        logic c, v, lt, eq, gt;
        c  = 1'b0;
        v  = 1'b0;
        o  = 16'h0;
        w  = 17'h0;
        lt = $signed(x) <  $signed(y);
        eq = (x == y);
        gt = $signed(x) >  $signed(y);
        case (op)
            3'd0, 3'd6: begin
                w = {1'b0, x} + {1'b0, y};
                o = w[15:0];
                c = w[16];
                v = (x[15] == y[15]) && (o[15] != x[15]);
            end
            3'd1, 3'd5: begin
                w = {1'b0, x} + {1'b0, ~y} + 17'd1;
                o = w[15:0];
                c = w[16];
                v = (x[15] != y[15]) && (o[15] != x[15]);
            end
            3'd2:    o = x & y;
            3'd3:    o = x | y;
            3'd4:    o = lt ? 16'd1 : 16'd0;
            default: o = 16'h0;
        endcase
        return {o, c, lt, eq, gt, v};
    endfunction

    always_comb begin
        {alu_out, alu_cout, alu_lt, alu_eq, alu_gt, alu_ov} = alu_f(alu_x, alu_y, alu_op);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            failed++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] rtype(input int op, input int rd, input int rs, input int rt);
        return {op[3:0], rd[2:0], rs[2:0], rt[2:0], 3'b000};
    endfunction

    function automatic logic [15:0] itype(input int op, input int a, input int b, input int imm);
        return {op[3:0], a[2:0], b[2:0], imm[5:0]};
    endfunction

    task automatic sweep_regs(input string tag);
        for (int i = 0; i < 8; i++) begin
            dbg_raddr = i[2:0];
            #1;
            check(tag, dbg_rdata, model[i]);
        end
    endtask

    task automatic apply_reset();
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_instr  = 16'h0;
        rsp_ready = 1'b0;
        ext_we    = 1'b0;
        ext_waddr = 3'd0;
        ext_wdata = 16'h0;
        dbg_raddr = 3'd0;
        for (int i = 0; i < 8; i++) model[i] = 16'h0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic preload(input int a, input logic [15:0] d);
        @(negedge clk);
        ext_we    = 1'b1;
        ext_waddr = a[2:0];
        ext_wdata = d;
        @(posedge clk);
        #1;
        ext_we = 1'b0;
        if (a != 0) model[a] = d;
    endtask

    // Issues one instruction (optionally with a same-cycle preload), checks the
    // response against the model, stalls rsp_ready, then completes the handshake.
    task automatic run_instr(input logic [15:0] instr, input int stall,
                             input bit ext_en, input int ext_a, input logic [15:0] ext_d);
        int          lat;
        int          exp_lat;
        logic [3:0]  op;
        logic [15:0] x, y, simm, e_data, e_off;
        logic [4:0]  e_flags;
        logic        e_br, e_err;
        logic [20:0] r;

        @(negedge clk);
        check("in_ready_idle", in_ready, 1);
        in_valid  = 1'b1;
        in_instr  = instr;
        ext_we    = ext_en;
        ext_waddr = ext_a[2:0];
        ext_wdata = ext_d;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        ext_we   = 1'b0;
        if (ext_en && ext_a != 0) model[ext_a] = ext_d;

        op      = instr[15:12];
        simm    = {{10{instr[5]}}, instr[5:0]};
        e_data  = 16'h0;
        e_flags = 5'h0;
        e_br    = 1'b0;
        e_off   = 16'h0;
        e_err   = 1'b0;
        exp_lat = 2;
        if (op > 4'd6) begin
            e_err   = 1'b1;
            exp_lat = 1;
        end else begin
            if (op == 4'd5) begin
                x = model[instr[11:9]];
                y = model[instr[8:6]];
            end else begin
                x = model[instr[8:6]];
                y = (op == 4'd6) ? simm : model[instr[5:3]];
            end
            r       = alu_f(x, y, op[2:0]);
            e_data  = r[20:5];
            e_flags = r[4:0];
            if (op == 4'd5) begin
                e_br  = (x != y);
                e_off = simm;
            end else if (instr[11:9] != 3'd0) begin
                model[instr[11:9]] = e_data;
            end
        end

        lat = 0;
        while (!rsp_valid && lat < 8) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check("latency", lat, exp_lat);
        check("rsp_data", rsp_data, e_data);
        check("rsp_flags", rsp_flags, e_flags);
        check("rsp_branch", rsp_branch, e_br);
        check("rsp_offset", rsp_offset, e_off);
        check("rsp_err", rsp_err, e_err);
        sweep_regs("reg_after_capture");

        for (int s = 0; s < stall; s++) begin
            @(negedge clk);
            ext_we    = 1'b1;
            ext_waddr = 3'd1 + 3'(s % 7);
            ext_wdata = 16'hDEAD;
            @(posedge clk);
            #1;
            ext_we = 1'b0;
            check("stall_valid", rsp_valid, 1);
            check("stall_ready", in_ready, 0);
            check("stall_data", rsp_data, e_data);
            check("stall_flags", rsp_flags, e_flags);
        end

        @(negedge clk);
        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        rsp_ready = 1'b0;
        check("post_hs_valid", rsp_valid, 0);
        check("post_hs_ready", in_ready, 1);
        if (stall > 0) sweep_regs("reg_after_stall");
    endtask

    initial begin
        apply_reset();
        // Reset values, sampled just after release
        check("rst_in_ready", in_ready, 1);
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_rsp_data", rsp_data, 0);
        check("rst_rsp_flags", rsp_flags, 0);
        check("rst_rsp_err", rsp_err, 0);
        check("rst_alu_x", alu_x, 0);
        check("rst_alu_y", alu_y, 0);
        check("rst_alu_op", alu_op, 0);
        check("alu_cin", alu_cin, 0);
        sweep_regs("rst_regs");

        // Directed scenarios
        preload(1, 16'h7FFF);
        preload(2, 16'h0001);
        run_instr(rtype(0, 3, 1, 2), 0, 0, 0, 16'h0);     // ADD overflow
        preload(1, 16'd5);
        preload(2, 16'd9);
        run_instr(rtype(4, 4, 1, 2), 0, 0, 0, 16'h0);     // SLT
        run_instr(rtype(1, 5, 1, 2), 0, 0, 0, 16'h0);     // SUB -> 0xFFFC
        run_instr(itype(6, 6, 0, 6'h3F), 0, 0, 0, 16'h0); // ADDI -> 0xFFFF
        run_instr(rtype(0, 0, 6, 6), 0, 0, 0, 16'h0);     // write to r0 dropped
        run_instr(itype(5, 1, 2, 6'h3E), 0, 0, 0, 16'h0); // BNE taken
        run_instr(itype(5, 1, 2, 6'h3E), 0, 1, 2, 16'd5); // same-cycle write makes r2=r1
        run_instr(16'hB000, 0, 0, 0, 16'h0);              // illegal op
        run_instr(rtype(2, 7, 5, 6), 10, 0, 0, 16'h0);    // long backpressure

        // Reset during ISSUE aborts the transaction
        preload(3, 16'h1234);
        @(negedge clk);
        in_valid = 1'b1;
        in_instr = rtype(0, 4, 3, 3);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        rst_n    = 1'b0;
        for (int i = 0; i < 8; i++) model[i] = 16'h0;
        #1;
        check("abort_rsp_valid", rsp_valid, 0);
        check("abort_in_ready", in_ready, 1);
        check("abort_alu_x", alu_x, 0);
        check("abort_alu_y", alu_y, 0);
        check("abort_rsp_data", rsp_data, 0);
        sweep_regs("abort_regs");
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(posedge clk);
            #1;
            check("abort_no_rsp", rsp_valid, 0);
        end
        sweep_regs("abort_regs_after");

        // Randomized traffic
        for (int t = 0; t < 40; t++) begin
            int          sel;
            logic [15:0] instr;
            if ($urandom_range(0, 3) == 0) preload($urandom_range(0, 7), 16'($urandom));
            sel   = $urandom_range(0, 8);
            instr = 16'($urandom);
            if (sel <= 6) instr[15:12] = sel[3:0];
            else          instr[15:12] = 4'($urandom_range(7, 15));
            if ($urandom_range(0, 4) == 0)
                run_instr(instr, $urandom_range(0, 2), 1, $urandom_range(0, 7), 16'($urandom));
            else
                run_instr(instr, $urandom_range(0, 2), 0, 0, 16'h0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule
